// File: rtl/phoenix_packet_sender_pkg.sv
// Shared Phoenix link definitions: flit width, flit-format indices and the sender FSM states.
package phoenix_packet_sender_pkg;
  localparam int TAM_FLIT = 16;
  localparam int HEADER_IDX = 0;
  localparam int SIZE_IDX   = 1;

  typedef logic [TAM_FLIT-1:0] flit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SIZE    = 2'd1,
    PAYLOAD = 2'd2
  } state_t;
endpackage

// File: rtl/phoenix_packet_sender_if.sv
// Core request/payload streams plus the router local-port link (tx/data_out/credit_i).
interface phoenix_packet_sender_if;
  import phoenix_packet_sender_pkg::*;

  logic  req_valid;
  flit_t req_target;
  flit_t req_size;
  logic  req_ready;
  logic  req_err;
  logic  pl_valid;
  flit_t pl_data;
  logic  pl_ready;
  logic  tx;
  flit_t data_out;
  logic  credit_i;

  modport slave (
    input  req_valid, req_target, req_size, pl_valid, pl_data, credit_i,
    output req_ready, req_err, pl_ready, tx, data_out
  );

  modport master (
    output req_valid, req_target, req_size, pl_valid, pl_data, credit_i,
    input  req_ready, req_err, pl_ready, tx, data_out
  );
endinterface

// File: rtl/phoenix_packet_sender.sv
// Serializes header, size and N payload flits into a router local port under credit flow control.
module phoenix_packet_sender
  import phoenix_packet_sender_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  phoenix_packet_sender_if.slave  link,
  output logic                    clock_tx,
  output logic                    busy,
  output logic                    pkt_done
);

  state_t state, state_n;
  logic   tx_q, tx_n;
  flit_t  data_q, data_n;
  logic   last_q, last_n;
  flit_t  size_q, size_n;
  flit_t  remaining, rem_n;
  logic   err_q, err_n;
  logic   req_ready, pl_ready;
  logic   adv;

  // Output register may load when empty or when its flit leaves at this edge.
  assign adv = !tx_q | link.credit_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      tx_q      <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      size_q    <= '0;
      remaining <= '0;
      err_q     <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      state     <= state_n;
      tx_q      <= tx_n;
      data_q    <= data_n;
      last_q    <= last_n;
      size_q    <= size_n;
      remaining <= rem_n;
      err_q     <= err_n;
      pkt_done  <= tx_q & link.credit_i & last_q;
    end
  end

  always_comb begin
    state_n   = state;
    tx_n      = tx_q;
    data_n    = data_q;
    last_n    = last_q;
    size_n    = size_q;
    rem_n     = remaining;
    err_n     = 1'b0;
    req_ready = 1'b0;
    pl_ready  = 1'b0;
    // A departing flit empties the register unless a state below reloads it.
    if (adv) begin
      tx_n   = 1'b0;
      last_n = 1'b0;
    end
    case (state)
      IDLE: begin
        req_ready = adv;
        if (link.req_valid && adv) begin
          if (link.req_size != '0) begin
            data_n  = link.req_target;
            tx_n    = 1'b1;
            size_n  = link.req_size;
            state_n = SIZE;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      SIZE: begin
        if (adv) begin
          data_n  = size_q;
          tx_n    = 1'b1;
          rem_n   = size_q;
          state_n = PAYLOAD;
        end
      end
      PAYLOAD: begin
        pl_ready = adv;
        if (adv && link.pl_valid) begin
          data_n = link.pl_data;
          tx_n   = 1'b1;
          rem_n  = remaining - flit_t'(1);
          if (remaining == flit_t'(1)) begin
            last_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign link.req_ready = req_ready;
  assign link.pl_ready  = pl_ready;
  assign link.req_err   = err_q;
  assign link.tx        = tx_q;
  assign link.data_out  = data_q;
  assign clock_tx       = clock;
  assign busy           = (state != IDLE) | tx_q;

endmodule

// File: tb/tb_phoenix_packet_sender.sv
// Randomized and directed bench for phoenix_packet_sender against a flit-stream reference model.
module tb_phoenix_packet_sender;
  import phoenix_packet_sender_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clock_tx, busy, pkt_done;

  phoenix_packet_sender_if bus();

  phoenix_packet_sender dut (
    .clock    (clock),
    .reset    (reset),
    .link     (bus),
    .clock_tx (clock_tx),
    .busy     (busy),
    .pkt_done (pkt_done)
  );

  always #5 clock = ~clock;

  flit_t rq_t[$], rq_n[$], plq[$];
  flit_t flits[$], dtrace[$];
  int    done_marks[$];
  bit    tx_trace[$];
  int    err_seen, hold_bad;
  bit    busy_seen, stall_plr_bad;
  int    stall_cnt, bubble_pending;
  flit_t stall_val, stop_val;
  bit    use_stop, rand_credit, rand_pl;
  int    checks, passes;

  flit_t exp_q[$];
  int    exp_ends[$];
  int    exp_err;

  task automatic clear_rec();
    flits.delete(); dtrace.delete(); done_marks.delete(); tx_trace.delete();
    err_seen = 0; hold_bad = 0; busy_seen = 0; stall_plr_bad = 0;
  endtask

  // Reference: the link carries, for every non-empty request, target, N, then N payload flits in order.
  task automatic build_model();
    int cum = 0, pi = 0;
    exp_q.delete(); exp_ends.delete(); exp_err = 0;
    foreach (rq_t[i]) begin
      if (rq_n[i] == 0) begin
        exp_err++;
      end else begin
        exp_q.push_back(rq_t[i]);
        exp_q.push_back(rq_n[i]);
        for (int k = 0; k < int'(rq_n[i]); k++) exp_q.push_back(plq[pi + k]);
        pi  += int'(rq_n[i]);
        cum += int'(rq_n[i]) + 2;
        exp_ends.push_back(cum);
      end
    end
  endtask

  function automatic int first_diff(input flit_t a[$], input flit_t b[$]);
    int n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  function automatic int first_diff_int(input int a[$], input int b[$]);
    int n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  function automatic void tx_stats(input bit q[$], output int ones, output int span);
    int first = -1, last = -1;
    ones = 0;
    foreach (q[i]) if (q[i]) begin
      ones++;
      if (first < 0) first = i;
      last = i;
    end
    span = (first < 0) ? 0 : last - first + 1;
  endfunction

  // Drives requests/payload from the queues one cycle per negedge and records what crosses the link.
  task automatic run(input int max_cyc, output bit timeout);
    int  c = 0;
    bit  fin = 0, stalled, prev_v = 0;
    flit_t prev_d = '0;
    timeout = 0;
    while (!fin) begin
      @(negedge clock);
      if (pkt_done) done_marks.push_back(flits.size());
      if (bus.req_err) err_seen++;
      if (busy) busy_seen = 1;
      if (prev_v && (!bus.tx || bus.data_out !== prev_d)) hold_bad++;
      tx_trace.push_back(bus.tx);
      dtrace.push_back(bus.data_out);
      if (use_stop && bus.tx && bus.data_out == stop_val) begin
        fin = 1;
      end else if (rq_t.size() == 0 && plq.size() == 0 && !busy) begin
        fin = 1;
      end else if (c >= max_cyc) begin
        timeout = 1;
        fin = 1;
      end else begin
        c++;
        stalled = (stall_cnt > 0 && bus.tx && bus.data_out == stall_val);
        if (stalled) begin
          bus.credit_i = 1'b0;
          stall_cnt--;
        end else begin
          bus.credit_i = rand_credit ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        bus.req_valid = (rq_t.size() != 0);
        bus.req_target = (rq_t.size() != 0) ? rq_t[0] : flit_t'($urandom);
        bus.req_size   = (rq_n.size() != 0) ? rq_n[0] : flit_t'($urandom);
        if (bubble_pending > 0 && plq.size() == 1 && bus.pl_ready !== 1'bx && dut.state == PAYLOAD) begin
          bus.pl_valid = 1'b0;
          bubble_pending--;
        end else begin
          bus.pl_valid = (plq.size() != 0) && (!rand_pl || $urandom_range(0, 2) != 0);
        end
        bus.pl_data = (plq.size() != 0) ? plq[0] : flit_t'($urandom);
        #1;
        if (stalled && bus.pl_ready) stall_plr_bad = 1;
        prev_v = bus.tx && !bus.credit_i;
        prev_d = bus.data_out;
        if (bus.req_valid && bus.req_ready) begin
          void'(rq_t.pop_front());
          void'(rq_n.pop_front());
        end
        if (bus.pl_valid && bus.pl_ready) void'(plq.pop_front());
        if (bus.tx && bus.credit_i) flits.push_back(bus.data_out);
      end
    end
    bus.req_valid = 1'b0;
    bus.pl_valid  = 1'b0;
  endtask

  task automatic setup_basic(input flit_t tgt, input int n);
    rq_t.delete(); rq_n.delete(); plq.delete();
    rq_t.push_back(tgt);
    rq_n.push_back(flit_t'(n));
    for (int i = 0; i < n; i++) plq.push_back(flit_t'(16'hA000 + (i << 4) + $urandom_range(0, 15)));
    build_model();
    clear_rec();
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b1; bus.req_target = 16'h1234; bus.req_size = 16'h0002;
    bus.pl_valid = 1'b1; bus.pl_data = 16'h5678; bus.credit_i = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (bus.tx !== 1'b0) $display("FAIL reset_tx: got %b expected 0", bus.tx); else passes++;
    checks++; if (bus.data_out !== 16'h0) $display("FAIL reset_data: got %h expected 0000", bus.data_out); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (pkt_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", pkt_done); else passes++;
    checks++; if (bus.req_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", bus.req_err); else passes++;
    bus.req_valid = 1'b0; bus.pl_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    #1;
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.req_ready); else passes++;
  endtask

  task automatic test_basic();
    bit to; int ones, span, d;
    setup_basic(16'h0011, 3);
    run(2000, to);
    tx_stats(tx_trace, ones, span);
    d = first_diff(flits, exp_q);
    checks++; if (to) $display("FAIL basic_timeout: got timeout expected completion"); else passes++;
    checks++; if (d >= 0) $display("FAIL basic_stream: first difference at flit %0d, got %0d flits expected %0d", d, flits.size(), exp_q.size()); else passes++;
    checks++; if (ones != 5 || span != 5) $display("FAIL basic_tx_run: got %0d ones over %0d cycles expected 5 over 5", ones, span); else passes++;
    d = first_diff_int(done_marks, exp_ends);
    checks++; if (d >= 0) $display("FAIL basic_done: got %0d pulses expected %0d", done_marks.size(), exp_ends.size()); else passes++;
  endtask

  task automatic test_stall();
    bit to; int d, hold = 0;
    setup_basic(16'h0011, 3);
    stall_val = 16'h0003; stall_cnt = 2;
    run(2000, to);
    foreach (dtrace[i]) if (tx_trace[i] && dtrace[i] == 16'h0003) hold++;
    d = first_diff(flits, exp_q);
    checks++; if (d >= 0 || to) $display("FAIL stall_stream: first difference at flit %0d, got %0d flits expected %0d", d, flits.size(), exp_q.size()); else passes++;
    checks++; if (hold != 3) $display("FAIL stall_hold: got %0d cycles of size flit expected 3", hold); else passes++;
    checks++; if (stall_plr_bad) $display("FAIL stall_pl_ready: got pl_ready=1 during stall expected 0"); else passes++;
    checks++; if (done_marks.size() != 1 || stall_cnt != 0) $display("FAIL stall_done: got %0d pulses expected 1", done_marks.size()); else passes++;
  endtask

  task automatic test_bubble();
    bit to; int ones, span, d;
    setup_basic(16'h0011, 3);
    bubble_pending = 1;
    run(2000, to);
    tx_stats(tx_trace, ones, span);
    d = first_diff(flits, exp_q);
    checks++; if (d >= 0 || to) $display("FAIL bubble_stream: first difference at flit %0d, got %0d flits expected %0d", d, flits.size(), exp_q.size()); else passes++;
    checks++; if (ones != 5 || span != 6) $display("FAIL bubble_tx_run: got %0d ones over %0d cycles expected 5 over 6", ones, span); else passes++;
    checks++; if (bubble_pending != 0) $display("FAIL bubble_applied: got %0d pending expected 0", bubble_pending); else passes++;
    d = first_diff_int(done_marks, exp_ends);
    checks++; if (d >= 0) $display("FAIL bubble_done: got %0d pulses expected %0d", done_marks.size(), exp_ends.size()); else passes++;
  endtask

  task automatic test_back_to_back();
    bit to; int ones, span, d;
    rq_t.delete(); rq_n.delete(); plq.delete();
    rq_t.push_back(16'h00A1); rq_n.push_back(16'd1);
    rq_t.push_back(16'h00B2); rq_n.push_back(16'd2);
    plq.push_back(16'hC001); plq.push_back(16'hC002); plq.push_back(16'hC003);
    build_model();
    clear_rec();
    run(2000, to);
    tx_stats(tx_trace, ones, span);
    d = first_diff(flits, exp_q);
    checks++; if (d >= 0 || to) $display("FAIL b2b_stream: first difference at flit %0d, got %0d flits expected %0d", d, flits.size(), exp_q.size()); else passes++;
    checks++; if (ones != 7 || span != 7) $display("FAIL b2b_tx_run: got %0d ones over %0d cycles expected 7 over 7", ones, span); else passes++;
    d = first_diff_int(done_marks, exp_ends);
    checks++; if (d >= 0) $display("FAIL b2b_done: got %0d pulses expected %0d", done_marks.size(), exp_ends.size()); else passes++;
    checks++; if (done_marks.size() == 2 && done_marks[0] != 3) $display("FAIL b2b_first_done: got mark %0d expected 3", done_marks[0]); else passes++;
  endtask

  task automatic test_zero_size();
    bit to; int ones, span;
    rq_t.delete(); rq_n.delete(); plq.delete();
    rq_t.push_back(16'h0055); rq_n.push_back(16'd0);
    build_model();
    clear_rec();
    run(2000, to);
    repeat (2) begin
      @(negedge clock);
      if (bus.req_err) err_seen++;
      if (busy) busy_seen = 1;
      tx_trace.push_back(bus.tx);
    end
    tx_stats(tx_trace, ones, span);
    checks++; if (rq_t.size() != 0 || to) $display("FAIL zero_accept: got %0d pending requests expected 0", rq_t.size()); else passes++;
    checks++; if (err_seen != exp_err) $display("FAIL zero_err: got %0d err cycles expected %0d", err_seen, exp_err); else passes++;
    checks++; if (ones != 0 || flits.size() != 0) $display("FAIL zero_tx: got %0d tx cycles expected 0", ones); else passes++;
    checks++; if (busy_seen) $display("FAIL zero_busy: got busy=1 expected 0"); else passes++;
  endtask

  task automatic test_mid_reset();
    bit to; int d;
    setup_basic(16'h0077, 4);
    stop_val = plq[1];
    use_stop = 1'b1;
    run(2000, to);
    use_stop = 1'b0;
    checks++; if (to) $display("FAIL mreset_reach: got timeout expected second payload on tx"); else passes++;
    reset = 1'b1;
    @(negedge clock);
    checks++; if (bus.tx !== 1'b0 || bus.data_out !== 16'h0) $display("FAIL mreset_link: got tx=%b data=%h expected tx=0 data=0000", bus.tx, bus.data_out); else passes++;
    checks++; if (busy !== 1'b0 || pkt_done !== 1'b0) $display("FAIL mreset_busy: got busy=%b done=%b expected 0 0", busy, pkt_done); else passes++;
    reset = 1'b0;
    setup_basic(16'h0088, 2);
    run(2000, to);
    d = first_diff(flits, exp_q);
    checks++; if (d >= 0 || to) $display("FAIL mreset_after: first difference at flit %0d, got %0d flits expected %0d", d, flits.size(), exp_q.size()); else passes++;
    d = first_diff_int(done_marks, exp_ends);
    checks++; if (d >= 0) $display("FAIL mreset_done: got %0d pulses expected %0d", done_marks.size(), exp_ends.size()); else passes++;
  endtask

  task automatic test_random(input int iter);
    bit to; int d, n;
    rq_t.delete(); rq_n.delete(); plq.delete();
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(0, 6);
      rq_t.push_back(flit_t'($urandom));
      rq_n.push_back(flit_t'(n));
      for (int k = 0; k < n; k++) plq.push_back(flit_t'($urandom));
    end
    build_model();
    clear_rec();
    rand_credit = 1'b1; rand_pl = 1'b1;
    run(4000, to);
    rand_credit = 1'b0; rand_pl = 1'b0;
    d = first_diff(flits, exp_q);
    checks++; if (d >= 0 || to) $display("FAIL rand%0d_stream: first difference at flit %0d, got %0d flits expected %0d", iter, d, flits.size(), exp_q.size()); else passes++;
    d = first_diff_int(done_marks, exp_ends);
    checks++; if (d >= 0) $display("FAIL rand%0d_done: got %0d pulses expected %0d", iter, done_marks.size(), exp_ends.size()); else passes++;
    checks++; if (err_seen != exp_err) $display("FAIL rand%0d_err: got %0d err cycles expected %0d", iter, err_seen, exp_err); else passes++;
    checks++; if (hold_bad != 0) $display("FAIL rand%0d_hold: got %0d unstable stalls expected 0", iter, hold_bad); else passes++;
  endtask

  initial begin
    checks = 0; passes = 0;
    stall_cnt = 0; bubble_pending = 0; use_stop = 0; rand_credit = 0; rand_pl = 0;
    stall_val = '0; stop_val = '0;
    bus.req_valid = 1'b0; bus.req_target = '0; bus.req_size = '0;
    bus.pl_valid = 1'b0; bus.pl_data = '0; bus.credit_i = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_bubble();
    test_back_to_back();
    test_zero_size();
    test_mid_reset();
    for (int i = 0; i < 4; i++) test_random(i);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
